// File: rtl/medidor_faixa_multi.sv
// medidor_faixa_multi
//   Round-robin range meter for N_CH ultrasonic sensors. Each channel gets a
//   trigger pulse, its echo is timed and converted to centimetres, and the
//   result is checked against a per-channel window with hysteresis. Each
//   result is published on a one-cycle valid strobe.
//
// Ports
//   clock, reset_n        system clock, asynchronous active-low reset
//   medir                 start one sweep of all channels (sampled in INICIAL)
//   continuo              sweep repeatedly while high
//   upperL, lowerL        window limits, channel i at [i*WIDTH +: WIDTH]
//   echo                  raw asynchronous echo inputs
//   trigger               trigger pulses, at most one high at a time
//   medida, medida_canal  last result (cm) and its channel
//   medida_valida, erro   result strobe, timeout strobe
//   dentro, acertou       per-channel inside-window flags, registered AND
//   db_estado             FSM state code
module medidor_faixa_multi #(
    parameter int unsigned N_CH            = 2,
    parameter int unsigned WIDTH           = 12,
    parameter int unsigned TRIG_CYCLES     = 500,
    parameter int unsigned CYCLES_PER_CM   = 2941,
    parameter int unsigned TIMEOUT_CYCLES  = 1500000,
    parameter int unsigned INTERVAL_CYCLES = 3000000,
    parameter int unsigned HYST            = 2,
    localparam int unsigned CW = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  medir,
    input  logic                  continuo,
    input  logic [N_CH*WIDTH-1:0] upperL,
    input  logic [N_CH*WIDTH-1:0] lowerL,
    input  logic [N_CH-1:0]       echo,
    output logic [N_CH-1:0]       trigger,
    output logic [WIDTH-1:0]      medida,
    output logic [CW-1:0]         medida_canal,
    output logic                  medida_valida,
    output logic                  erro,
    output logic [N_CH-1:0]       dentro,
    output logic                  acertou,
    output logic [3:0]            db_estado
);

    localparam logic [3:0] INICIAL     = 4'd0;
    localparam logic [3:0] PREPARA     = 4'd1;
    localparam logic [3:0] TRIGGER     = 4'd2;
    localparam logic [3:0] ESPERA_ECHO = 4'd3;
    localparam logic [3:0] MEDINDO     = 4'd4;
    localparam logic [3:0] ARMAZENA    = 4'd5;
    localparam logic [3:0] TIMEOUT     = 4'd6;
    localparam logic [3:0] INTERVALO   = 4'd7;
    localparam logic [3:0] PROX_CANAL  = 4'd8;

    localparam int unsigned CNT_MAX0 = (TIMEOUT_CYCLES > INTERVAL_CYCLES) ? TIMEOUT_CYCLES : INTERVAL_CYCLES;
    localparam int unsigned CNT_MAX  = (CNT_MAX0 > TRIG_CYCLES) ? CNT_MAX0 : TRIG_CYCLES;
    localparam int unsigned CNT_W    = $clog2(CNT_MAX + 1);
    localparam int unsigned SUB_W    = (CYCLES_PER_CM > 1) ? $clog2(CYCLES_PER_CM) : 1;

    localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(CYCLES_PER_CM - 1);
    localparam logic [WIDTH-1:0] CM_MAX   = {{(WIDTH-1){1'b1}}, 1'b0};
    localparam logic signed [WIDTH+1:0] HYST_S = (WIDTH+2)'(HYST);

    logic [N_CH-1:0]  echo_s1_q, echo_s2_q;
    logic [3:0]       state_q, state_d;
    logic [CW-1:0]    canal_q, canal_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [SUB_W-1:0] sub_q, sub_d;
    logic [WIDTH-1:0] cm_q, cm_d;
    logic [WIDTH-1:0] medida_q, medida_d;
    logic [CW-1:0]    mcanal_q, mcanal_d;
    logic             valida_q, valida_d;
    logic             erro_q, erro_d;
    logic [N_CH-1:0]  dentro_q, dentro_d;
    logic             acertou_q;

    logic             echo_cur;
    logic [SUB_W-1:0] sub_inc;
    logic [WIDTH-1:0] cm_inc;
    logic signed [WIDTH+1:0] m_s, lo_s, up_s;
    logic             dentro_next;

    assign echo_cur = echo_s2_q[canal_q];

    // One echo-high clock: advance the sub-counter, carry into cm (saturating).
    always_comb begin
        sub_inc = sub_q + SUB_W'(1);
        cm_inc  = cm_q;
        if (sub_q == SUB_LAST) begin
            sub_inc = '0;
            cm_inc  = (cm_q == CM_MAX) ? cm_q : cm_q + WIDTH'(1);
        end
    end

    // Window check in WIDTH+2 signed bits so limit +/- HYST never wraps.
    always_comb begin
        m_s  = $signed({2'b00, cm_q});
        lo_s = $signed({2'b00, lowerL[canal_q*WIDTH +: WIDTH]});
        up_s = $signed({2'b00, upperL[canal_q*WIDTH +: WIDTH]});
        if (lo_s > up_s)
            dentro_next = 1'b0;
        else if (m_s >= lo_s && m_s <= up_s)
            dentro_next = 1'b1;
        else if (m_s < lo_s - HYST_S || m_s > up_s + HYST_S)
            dentro_next = 1'b0;
        else
            dentro_next = dentro_q[canal_q];
    end

    always_comb begin
        state_d  = state_q;
        canal_d  = canal_q;
        cnt_d    = cnt_q;
        sub_d    = sub_q;
        cm_d     = cm_q;
        medida_d = medida_q;
        mcanal_d = mcanal_q;
        valida_d = 1'b0;
        erro_d   = 1'b0;
        dentro_d = dentro_q;
        case (state_q)
            INICIAL: begin
                if (medir || continuo) begin
                    state_d = PREPARA;
                    canal_d = '0;
                end
            end
            PREPARA: begin
                cnt_d   = '0;
                sub_d   = '0;
                cm_d    = '0;
                state_d = TRIGGER;
            end
            TRIGGER: begin
                if (cnt_q == CNT_W'(TRIG_CYCLES - 1)) begin
                    cnt_d   = '0;
                    state_d = ESPERA_ECHO;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ESPERA_ECHO: begin
                // The rise cycle itself is the first echo-high clock.
                if (echo_cur) begin
                    cnt_d   = CNT_W'(1);
                    sub_d   = sub_inc;
                    cm_d    = cm_inc;
                    state_d = MEDINDO;
                end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    state_d = TIMEOUT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            MEDINDO: begin
                if (!echo_cur) begin
                    state_d = ARMAZENA;
                end else if (cnt_q >= CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    state_d = TIMEOUT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    sub_d = sub_inc;
                    cm_d  = cm_inc;
                end
            end
            ARMAZENA: begin
                medida_d          = cm_q;
                mcanal_d          = canal_q;
                valida_d          = 1'b1;
                dentro_d[canal_q] = dentro_next;
                cnt_d             = '0;
                state_d           = INTERVALO;
            end
            TIMEOUT: begin
                medida_d          = '1;
                mcanal_d          = canal_q;
                valida_d          = 1'b1;
                erro_d            = 1'b1;
                dentro_d[canal_q] = 1'b0;
                cnt_d             = '0;
                state_d           = INTERVALO;
            end
            INTERVALO: begin
                if (cnt_q == CNT_W'(INTERVAL_CYCLES - 1))
                    state_d = PROX_CANAL;
                else
                    cnt_d = cnt_q + CNT_W'(1);
            end
            PROX_CANAL: begin
                if (canal_q != CW'(N_CH - 1)) begin
                    canal_d = canal_q + CW'(1);
                    state_d = PREPARA;
                end else if (continuo) begin
                    canal_d = '0;
                    state_d = PREPARA;
                end else begin
                    state_d = INICIAL;
                end
            end
            default: state_d = INICIAL;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            echo_s1_q <= '0;
            echo_s2_q <= '0;
            state_q   <= INICIAL;
            canal_q   <= '0;
            cnt_q     <= '0;
            sub_q     <= '0;
            cm_q      <= '0;
            medida_q  <= '0;
            mcanal_q  <= '0;
            valida_q  <= 1'b0;
            erro_q    <= 1'b0;
            dentro_q  <= '0;
            acertou_q <= 1'b0;
        end else begin
            echo_s1_q <= echo;
            echo_s2_q <= echo_s1_q;
            state_q   <= state_d;
            canal_q   <= canal_d;
            cnt_q     <= cnt_d;
            sub_q     <= sub_d;
            cm_q      <= cm_d;
            medida_q  <= medida_d;
            mcanal_q  <= mcanal_d;
            valida_q  <= valida_d;
            erro_q    <= erro_d;
            dentro_q  <= dentro_d;
            acertou_q <= &dentro_q;
        end
    end

    // Decoded from the state register so an async reset drops it at once.
    always_comb begin
        trigger = '0;
        if (state_q == TRIGGER)
            trigger[canal_q] = 1'b1;
    end

    assign medida        = medida_q;
    assign medida_canal  = mcanal_q;
    assign medida_valida = valida_q;
    assign erro          = erro_q;
    assign dentro        = dentro_q;
    assign acertou       = acertou_q;
    assign db_estado     = state_q;

endmodule

// File: tb/tb_medidor_faixa_multi.sv
// Self-checking bench for medidor_faixa_multi: directed sweeps with a
// result scoreboard, plus a narrow-width instance for cm saturation.
module tb_medidor_faixa_multi;

    typedef struct packed {
        logic        canal;
        logic [11:0] medida;
        logic        erro;
    } exp_t;

    logic        clock;
    logic        reset_n;
    logic        medir, continuo;
    logic [23:0] upperL, lowerL;
    logic        echo0, echo1;
    logic [1:0]  echo;
    logic [1:0]  trigger;
    logic [11:0] medida;
    logic        medida_canal;
    logic        medida_valida, erro;
    logic [1:0]  dentro;
    logic        acertou;
    logic [3:0]  db_estado;

    logic        medir_s, continuo_s, echo_s;
    logic [7:0]  upper_s, lower_s;
    logic        trig_s;
    logic [7:0]  medida_s;
    logic        canal_s, valida_s, erro_s, dentro_s, acertou_s;
    logic [3:0]  estado_s;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int len0 = 0;
    int len1 = 0;
    exp_t sb[$];
    exp_t mon_e, mon_o;

    assign echo = {echo1, echo0};

    medidor_faixa_multi #(
        .N_CH(2), .WIDTH(12), .TRIG_CYCLES(4), .CYCLES_PER_CM(10),
        .TIMEOUT_CYCLES(2000), .INTERVAL_CYCLES(50), .HYST(2)
    ) dut (
        .clock(clock), .reset_n(reset_n), .medir(medir), .continuo(continuo),
        .upperL(upperL), .lowerL(lowerL), .echo(echo), .trigger(trigger),
        .medida(medida), .medida_canal(medida_canal), .medida_valida(medida_valida),
        .erro(erro), .dentro(dentro), .acertou(acertou), .db_estado(db_estado)
    );

    medidor_faixa_multi #(
        .N_CH(1), .WIDTH(8), .TRIG_CYCLES(4), .CYCLES_PER_CM(1),
        .TIMEOUT_CYCLES(2000), .INTERVAL_CYCLES(50), .HYST(2)
    ) dut_s (
        .clock(clock), .reset_n(reset_n), .medir(medir_s), .continuo(continuo_s),
        .upperL(upper_s), .lowerL(lower_s), .echo(echo_s), .trigger(trig_s),
        .medida(medida_s), .medida_canal(canal_s), .medida_valida(valida_s),
        .erro(erro_s), .dentro(dentro_s), .acertou(acertou_s), .db_estado(estado_s)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;
    always @(posedge clock) cyc++;

    // Sensor models: echo starts 3 clocks after the trigger falls, high len clocks.
    initial begin
        echo0 = 1'b0;
        forever begin
            @(negedge trigger[0]);
            if (len0 > 0) begin
                repeat (3) @(posedge clock);
                #1 echo0 = 1'b1;
                repeat (len0) @(posedge clock);
                #1 echo0 = 1'b0;
            end
        end
    end

    initial begin
        echo1 = 1'b0;
        forever begin
            @(negedge trigger[1]);
            if (len1 > 0) begin
                repeat (3) @(posedge clock);
                #1 echo1 = 1'b1;
                repeat (len1) @(posedge clock);
                #1 echo1 = 1'b0;
            end
        end
    end

    // Scoreboard monitor
    always @(negedge clock) begin
        if (reset_n && medida_valida) begin
            checks++;
            assert (sb.size() > 0) else begin
                errors++;
                $error("FAIL unexpected_result: got canal=%0d medida=%0d erro=%0b, expected none",
                       medida_canal, medida, erro);
            end
            if (sb.size() > 0) begin
                mon_e = sb.pop_front();
                mon_o = '{canal: medida_canal, medida: medida, erro: erro};
                checks++;
                assert (mon_o === mon_e) else begin
                    errors++;
                    $error("FAIL result: got canal=%0d medida=%0d erro=%0b, expected canal=%0d medida=%0d erro=%0b",
                           mon_o.canal, mon_o.medida, mon_o.erro, mon_e.canal, mon_e.medida, mon_e.erro);
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic wait_trig_high(input int ch, input int budget);
        int n = 0;
        @(negedge clock);
        while (trigger[ch] !== 1'b1 && n < budget) begin
            @(negedge clock);
            n++;
        end
        chk($sformatf("wait_trigger%0d", ch), 32'(trigger[ch]), 32'd1);
    endtask

    task automatic wait_valid_ch(input int ch, input int budget);
        int n = 0;
        @(negedge clock);
        while (!(medida_valida === 1'b1 && medida_canal == 1'(ch)) && n < budget) begin
            @(negedge clock);
            n++;
        end
        chk($sformatf("wait_valid_ch%0d", ch), 32'(medida_valida), 32'd1);
    endtask

    task automatic wait_state(input logic [3:0] s, input int budget);
        int n = 0;
        @(negedge clock);
        while (db_estado !== s && n < budget) begin
            @(negedge clock);
            n++;
        end
        chk($sformatf("wait_state%0d", s), 32'(db_estado), 32'(s));
    endtask

    task automatic pulse_medir();
        @(negedge clock);
        medir = 1'b1;
        @(negedge clock);
        medir = 1'b0;
    endtask

    task automatic push(input logic c, input logic [11:0] m, input logic e);
        sb.push_back('{canal: c, medida: m, erro: e});
    endtask

    initial begin
        int lens[5];
        int exp_d0[5];
        int w, t0, t1, bad, n;
        lens   = '{155, 215, 235, 215, 205};
        exp_d0 = '{1, 1, 0, 0, 1};

        reset_n = 1'b0; medir = 1'b0; continuo = 1'b0;
        upperL = {12'd8, 12'd20};
        lowerL = {12'd5, 12'd10};
        medir_s = 1'b0; continuo_s = 1'b0; echo_s = 1'b0;
        upper_s = 8'd200; lower_s = 8'd100;

        // Reset state
        repeat (3) @(negedge clock);
        chk("rst_trigger", 32'(trigger), 0);
        chk("rst_medida", 32'(medida), 0);
        chk("rst_canal", 32'(medida_canal), 0);
        chk("rst_valida", 32'(medida_valida), 0);
        chk("rst_erro", 32'(erro), 0);
        chk("rst_dentro", 32'(dentro), 0);
        chk("rst_acertou", 32'(acertou), 0);
        chk("rst_estado", 32'(db_estado), 0);
        reset_n = 1'b1;
        repeat (3) @(negedge clock);
        chk("idle_estado", 32'(db_estado), 0);

        // Single sweep
        len0 = 155; len1 = 62;
        push(1'b0, 12'd15, 1'b0);
        push(1'b1, 12'd6, 1'b0);
        pulse_medir();
        wait_trig_high(0, 20);
        w = 0;
        while (trigger[0] === 1'b1 && w < 20) begin
            w++;
            @(negedge clock);
        end
        chk("trig0_width", 32'(w), 4);
        wait_trig_high(1, 500);
        chk("trig_onehot", 32'(trigger), 32'h2);
        wait_state(4'd0, 1000);
        chk("sweep_dentro", 32'(dentro), 32'h3);
        chk("sweep_acertou", 32'(acertou), 1);
        chk("sweep_sb_empty", 32'(sb.size()), 0);

        // Hysteresis on ch0 in continuous mode; continuo dropped in the last ch0 MEDINDO
        for (int k = 0; k < 5; k++) begin
            len0 = lens[k];
            push(1'b0, 12'(lens[k] / 10), 1'b0);
            push(1'b1, 12'd6, 1'b0);
            if (k == 0) begin
                @(negedge clock);
                continuo = 1'b1;
            end
            if (k == 4) begin
                wait_state(4'd4, 400);
                continuo = 1'b0;
            end
            wait_valid_ch(1, 1000);
            repeat (2) @(negedge clock);
            chk($sformatf("hyst_dentro0_%0d", k), 32'(dentro[0]), 32'(exp_d0[k]));
            chk($sformatf("hyst_acertou_%0d", k), 32'(acertou), 32'(exp_d0[k]));
        end
        wait_state(4'd0, 500);
        bad = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clock);
            if (trigger !== 2'b00 || db_estado !== 4'd0) bad++;
        end
        chk("stop_no_activity", 32'(bad), 0);

        // Timeout on ch1
        len0 = 155; len1 = 0;
        push(1'b0, 12'd15, 1'b0);
        push(1'b1, 12'hFFF, 1'b1);
        pulse_medir();
        wait_trig_high(1, 500);
        n = 0;
        while (trigger[1] === 1'b1 && n < 20) begin
            @(negedge clock);
            n++;
        end
        t0 = cyc;
        wait_valid_ch(1, 2100);
        t1 = cyc;
        chk("timeout_latency", 32'((t1 - t0 >= 2000) && (t1 - t0 <= 2004)), 1);
        chk("timeout_erro", 32'(erro), 1);
        @(negedge clock);
        chk("timeout_strobe_len", 32'({medida_valida, erro}), 0);
        wait_state(4'd0, 200);
        chk("timeout_dentro", 32'(dentro), 32'h1);
        chk("timeout_acertou", 32'(acertou), 0);

        // Reset while trigger0 is high
        len0 = 155; len1 = 62;
        pulse_medir();
        wait_trig_high(0, 20);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_trigger", 32'(trigger), 0);
        chk("arst_estado", 32'(db_estado), 0);
        chk("arst_medida", 32'(medida), 0);
        chk("arst_dentro", 32'(dentro), 0);
        chk("arst_acertou", 32'(acertou), 0);
        @(negedge clock);
        reset_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clock);
            if (trigger !== 2'b00 || medida_valida !== 1'b0 || db_estado !== 4'd0) bad++;
        end
        chk("arst_quiet", 32'(bad), 0);

        // Recovery sweep after reset
        push(1'b0, 12'd15, 1'b0);
        push(1'b1, 12'd6, 1'b0);
        pulse_medir();
        wait_valid_ch(1, 1000);
        wait_state(4'd0, 200);
        chk("recover_dentro", 32'(dentro), 32'h3);
        chk("recover_acertou", 32'(acertou), 1);

        // Saturation on the 8-bit instance (CYCLES_PER_CM=1)
        @(negedge clock);
        medir_s = 1'b1;
        @(negedge clock);
        medir_s = 1'b0;
        n = 0;
        while (trig_s !== 1'b1 && n < 20) begin @(negedge clock); n++; end
        while (trig_s === 1'b1 && n < 40) begin @(negedge clock); n++; end
        echo_s = 1'b1;
        repeat (1999) @(negedge clock);
        echo_s = 1'b0;
        n = 0;
        while (valida_s !== 1'b1 && n < 50) begin @(negedge clock); n++; end
        chk("sat_valid", 32'(valida_s), 1);
        chk("sat_medida", 32'(medida_s), 254);
        chk("sat_erro", 32'(erro_s), 0);
        n = 0;
        while (estado_s !== 4'd0 && n < 200) begin @(negedge clock); n++; end
        @(negedge clock);
        medir_s = 1'b1;
        @(negedge clock);
        medir_s = 1'b0;
        n = 0;
        while (trig_s !== 1'b1 && n < 20) begin @(negedge clock); n++; end
        while (trig_s === 1'b1 && n < 40) begin @(negedge clock); n++; end
        echo_s = 1'b1;
        n = 0;
        while (valida_s !== 1'b1 && n < 2200) begin @(negedge clock); n++; end
        chk("sat_to_valid", 32'(valida_s), 1);
        chk("sat_to_medida", 32'(medida_s), 255);
        chk("sat_to_erro", 32'(erro_s), 1);
        echo_s = 1'b0;

        repeat (5) @(negedge clock);
        chk("final_sb_empty", 32'(sb.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
